// File: rtl/mem_stage_hs_if.sv
// mem_stage_hs_if: data-memory request/acknowledge bus between the MEM stage
// and an external variable-latency data memory.
//   master (MEM stage): drives mem_req, mem_we, mem_addr, mem_be, mem_wdata;
//                       samples mem_ack, mem_rdata
//   slave  (memory)   : the mirror image
// mem_rdata is only meaningful in a cycle where mem_ack=1 and mem_req=1.
interface mem_stage_hs_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_stage_hs.sv
// mem_stage_hs: MIPS memory stage with a req/ack data-memory handshake and
// the MEM/WB pipeline register.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   *M inputs           : control/data from the EX/MEM register
//   mem                 : data-memory bus (master side)
//   stallM              : holds F/D/E/M while an access is outstanding
//   WriteRegM_hazard    : combinational copy of WriteRegM for forwarding
//   *W outputs          : registered MEM/WB results and one-cycle exception flags
// Byte/half/word accesses with sign/zero-extended loads; misaligned accesses
// complete at once with exc_misalignW, unacknowledged accesses end with
// exc_buserrW after TIMEOUT cycles in WAIT.
module mem_stage_hs #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWriteM,
  input  logic              MemToRegM,
  input  logic              MemWriteM,
  input  logic              syscallM,
  input  logic [1:0]        SizeM,
  input  logic              SignedM,
  input  logic [ADDR_W-1:0] ALUOutM,
  input  logic [31:0]       WriteDataM,
  input  logic [REG_W-1:0]  WriteRegM,
  mem_stage_hs_if.master    mem,
  output logic              stallM,
  output logic [REG_W-1:0]  WriteRegM_hazard,
  output logic              RegWriteW,
  output logic              MemtoRegW,
  output logic              syscallW,
  output logic [31:0]       ReadDataW,
  output logic [ADDR_W-1:0] ALUOutW,
  output logic [REG_W-1:0]  WriteRegW,
  output logic              exc_misalignW,
  output logic              exc_buserrW
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, WAIT} state_e;

  typedef struct packed {
    logic              regwrite;
    logic              memtoreg;
    logic              syscall;
    logic [31:0]       rdata;
    logic [ADDR_W-1:0] aluout;
    logic [REG_W-1:0]  wreg;
    logic              misalign;
    logic              buserr;
  } wb_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  wb_t              wb_q, wb_d;

  logic        is_byte, is_half;
  logic        mem_op, misalign;
  logic        req, timeout, complete;
  logic [31:0] rdata_sh;
  logic [31:0] load_data;

  // Access decode (SizeM=11 behaves as a word)
  assign is_byte  = (SizeM == 2'b00);
  assign is_half  = (SizeM == 2'b01);
  assign mem_op   = MemToRegM | MemWriteM;
  assign misalign = mem_op & ((is_half & ALUOutM[0]) |
                              (!is_byte && !is_half && (ALUOutM[1:0] != 2'b00)));

  // Bus drive: upstream holds the M inputs steady while stalled, so the
  // same decode serves both the IDLE issue cycle and every WAIT cycle.
  assign mem.mem_we   = MemWriteM;
  assign mem.mem_addr = {ALUOutM[ADDR_W-1:2], 2'b00};

  always_comb begin
    mem.mem_be    = 4'b1111;
    mem.mem_wdata = WriteDataM;
    if (is_byte) begin
      mem.mem_be    = 4'b0001 << ALUOutM[1:0];
      mem.mem_wdata = {4{WriteDataM[7:0]}};
    end else if (is_half) begin
      mem.mem_be    = ALUOutM[1] ? 4'b1100 : 4'b0011;
      mem.mem_wdata = {2{WriteDataM[15:0]}};
    end
  end

  // Load lane select and extension
  assign rdata_sh = mem.mem_rdata >> {ALUOutM[1:0], 3'b000};

  always_comb begin
    load_data = mem.mem_rdata;
    if (is_byte) begin
      load_data = {{24{SignedM & rdata_sh[7]}}, rdata_sh[7:0]};
    end else if (is_half) begin
      load_data = {{16{SignedM & rdata_sh[15]}}, rdata_sh[15:0]};
    end
  end

  // Handshake FSM: next state, request, completion
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req      = 1'b0;
    timeout  = 1'b0;
    complete = 1'b1;
    case (state_q)
      IDLE: begin
        req = mem_op & ~misalign;
        if (req && !mem.mem_ack) begin
          state_d  = WAIT;
          cnt_d    = CNT_W'(1);
          complete = 1'b0;
        end
      end
      WAIT: begin
        req = 1'b1;
        // ack takes priority over a timeout landing in the same cycle
        if (mem.mem_ack) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          timeout = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
          complete = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Request is abandoned the moment reset asserts
    if (!rst_n) begin
      req = 1'b0;
    end
  end

  assign mem.mem_req      = req;
  assign stallM           = req & ~mem.mem_ack & ~timeout;
  assign WriteRegM_hazard = WriteRegM;

  // MEM/WB next value: capture on completion, bubble (control cleared,
  // data fields held) while stalled.
  always_comb begin
    wb_d          = wb_q;
    wb_d.regwrite = 1'b0;
    wb_d.memtoreg = 1'b0;
    wb_d.syscall  = 1'b0;
    wb_d.misalign = 1'b0;
    wb_d.buserr   = 1'b0;
    if (complete) begin
      wb_d.regwrite = RegWriteM & ~misalign & ~timeout;
      wb_d.memtoreg = MemToRegM & ~misalign;
      wb_d.syscall  = syscallM;
      wb_d.rdata    = load_data;
      wb_d.aluout   = ALUOutM;
      wb_d.wreg     = WriteRegM;
      wb_d.misalign = misalign;
      wb_d.buserr   = timeout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_q    <= wb_d;
    end
  end

  assign RegWriteW     = wb_q.regwrite;
  assign MemtoRegW     = wb_q.memtoreg;
  assign syscallW      = wb_q.syscall;
  assign ReadDataW     = wb_q.rdata;
  assign ALUOutW       = wb_q.aluout;
  assign WriteRegW     = wb_q.wreg;
  assign exc_misalignW = wb_q.misalign;
  assign exc_buserrW   = wb_q.buserr;

endmodule

// File: tb/tb_mem_stage_hs.sv
module tb_mem_stage_hs;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              RegWriteM, MemToRegM, MemWriteM, syscallM, SignedM;
  logic [1:0]        SizeM;
  logic [ADDR_W-1:0] ALUOutM;
  logic [31:0]       WriteDataM;
  logic [REG_W-1:0]  WriteRegM;
  logic              stallM;
  logic [REG_W-1:0]  WriteRegM_hazard;
  logic              RegWriteW, MemtoRegW, syscallW;
  logic [31:0]       ReadDataW;
  logic [ADDR_W-1:0] ALUOutW;
  logic [REG_W-1:0]  WriteRegW;
  logic              exc_misalignW, exc_buserrW;

  mem_stage_hs_if #(.ADDR_W(ADDR_W)) bus ();

  mem_stage_hs #(.ADDR_W(ADDR_W), .REG_W(REG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteM(RegWriteM), .MemToRegM(MemToRegM), .MemWriteM(MemWriteM),
    .syscallM(syscallM), .SizeM(SizeM), .SignedM(SignedM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
    .mem(bus), .stallM(stallM), .WriteRegM_hazard(WriteRegM_hazard),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .syscallW(syscallW),
    .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WriteRegW(WriteRegW),
    .exc_misalignW(exc_misalignW), .exc_buserrW(exc_buserrW)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic mtr, input logic mw, input logic rw, input logic sgn,
                        input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] wreg, input logic sys);
    MemToRegM = mtr; MemWriteM = mw; RegWriteM = rw; SignedM = sgn; SizeM = sz;
    ALUOutM = addr; WriteDataM = wd; WriteRegM = wreg; syscallM = sys;
  endtask

  task automatic nop();
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 5'd0, 1'b0);
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
  endtask

  // Reference arithmetic for the bus lanes and load extension
  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [1:0] sz,
                                         input logic sgn, input int unsigned off);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rd >> (8 * off)) & 32'hFF;
      if (sgn && v >= 32'h80) v = v - 32'h100;
    end else if (sz == 2'd1) begin
      v = (rd >> (8 * off)) & 32'hFFFF;
      if (sgn && v >= 32'h8000) v = v - 32'h10000;
    end else v = rd;
    return v;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input int unsigned off);
    if (sz == 2'd0) return 4'(1 << off);
    if (sz == 2'd1) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [1:0] sz);
    if (sz == 2'd0) return (wd & 32'hFF) * 32'h01010101;
    if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  typedef struct {
    logic        mtr, mw, rw, sgn;
    logic [1:0]  sz;
    logic [31:0] addr, wd, rdata;
    logic        e_req;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_rd;
    logic        e_rw, e_mtr, e_mis, chk_rd;
  } vec_t;

  vec_t vt[13];

  initial begin
    vt[0]  = '{1,0,1,0,2'b10,32'h100,32'h0,32'hDEADBEEF, 1,4'hF,32'h0,32'hDEADBEEF, 1,1,0,1};
    vt[1]  = '{1,0,1,1,2'b00,32'h103,32'h0,32'h80FFFFFF, 1,4'h8,32'h0,32'hFFFFFF80, 1,1,0,1};
    vt[2]  = '{1,0,1,0,2'b00,32'h103,32'h0,32'h80FFFFFF, 1,4'h8,32'h0,32'h00000080, 1,1,0,1};
    vt[3]  = '{1,0,1,1,2'b01,32'h102,32'h0,32'h80011234, 1,4'hC,32'h0,32'hFFFF8001, 1,1,0,1};
    vt[4]  = '{1,0,1,0,2'b01,32'h100,32'h0,32'h8001F234, 1,4'h3,32'h0,32'h0000F234, 1,1,0,1};
    vt[5]  = '{0,1,0,0,2'b01,32'h202,32'h1234ABCD,32'h0, 1,4'hC,32'hABCDABCD,32'h0, 0,0,0,0};
    vt[6]  = '{0,1,0,0,2'b00,32'h301,32'h000000A5,32'h0, 1,4'h2,32'hA5A5A5A5,32'h0, 0,0,0,0};
    vt[7]  = '{1,0,1,0,2'b10,32'h101,32'h0,32'h0, 0,4'h0,32'h0,32'h0, 0,0,1,0};
    vt[8]  = '{1,0,1,1,2'b01,32'h103,32'h0,32'h0, 0,4'h0,32'h0,32'h0, 0,0,1,0};
    vt[9]  = '{0,0,1,0,2'b10,32'h55,32'h0,32'h0, 0,4'h0,32'h0,32'h0, 1,0,0,0};
    vt[10] = '{1,0,1,1,2'b11,32'h104,32'h0,32'h90000001, 1,4'hF,32'h0,32'h90000001, 1,1,0,1};
    vt[11] = '{1,0,1,1,2'b00,32'h101,32'h0,32'h00007F00, 1,4'h2,32'h0,32'h0000007F, 1,1,0,1};
    vt[12] = '{0,1,0,0,2'b11,32'h206,32'h11112222,32'h0, 0,4'h0,32'h0,32'h0, 0,0,1,0};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sc;
    bit done;

    // ---------------- reset: memory op presented while in reset
    set_op(1, 0, 1, 0, 2'b10, 32'h100, 32'h0, 5'd3, 0);
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    tick(); tick();
    chk("rst_req", bus.mem_req, 0);
    chk("rst_stall", stallM, 0);
    chk("rst_w", {RegWriteW, MemtoRegW, syscallW, exc_misalignW, exc_buserrW}, 0);
    chk("rst_wdata", {ReadDataW, ALUOutW}, 0);
    chk("rst_wreg", WriteRegW, 0);
    nop();
    rst_n = 1'b1;
    tick();

    // ---------------- single-cycle table vectors (ack in the same cycle)
    for (int i = 0; i < 13; i++) begin
      set_op(vt[i].mtr, vt[i].mw, vt[i].rw, vt[i].sgn, vt[i].sz, vt[i].addr, vt[i].wd,
             5'(i + 1), 1'b0);
      bus.mem_ack = 1'b1; bus.mem_rdata = vt[i].rdata;
      #4;
      chk($sformatf("vec%0d_req", i), bus.mem_req, vt[i].e_req);
      chk($sformatf("vec%0d_stall", i), stallM, 0);
      chk($sformatf("vec%0d_hazard", i), WriteRegM_hazard, 5'(i + 1));
      if (vt[i].e_req) begin
        chk($sformatf("vec%0d_be", i), bus.mem_be, vt[i].e_be);
        chk($sformatf("vec%0d_we", i), bus.mem_we, vt[i].mw);
        chk($sformatf("vec%0d_addr", i), bus.mem_addr, vt[i].addr & 32'hFFFFFFFC);
        if (vt[i].mw) chk($sformatf("vec%0d_wdata", i), bus.mem_wdata, vt[i].e_wd);
      end
      tick();
      chk($sformatf("vec%0d_rw", i), RegWriteW, vt[i].e_rw);
      chk($sformatf("vec%0d_mtr", i), MemtoRegW, vt[i].e_mtr);
      chk($sformatf("vec%0d_mis", i), exc_misalignW, vt[i].e_mis);
      chk($sformatf("vec%0d_berr", i), exc_buserrW, 0);
      chk($sformatf("vec%0d_alu", i), ALUOutW, vt[i].addr);
      chk($sformatf("vec%0d_wreg", i), WriteRegW, 5'(i + 1));
      if (vt[i].chk_rd) chk($sformatf("vec%0d_rd", i), ReadDataW, vt[i].e_rd);
    end

    // ---------------- lb / lbu at 0x103, ack after 3 cycles, back to back
    for (int s = 1; s >= 0; s--) begin
      set_op(1, 0, 1, 1'(s), 2'b00, 32'h103, 32'h0, 5'd9, 0);
      for (int c = 0; c <= 3; c++) begin
        bus.mem_ack = (c == 3);
        bus.mem_rdata = (c == 3) ? 32'h80FFFFFF : 32'h12345678;
        #4;
        chk($sformatf("slow%0d_req_c%0d", s, c), bus.mem_req, 1);
        chk($sformatf("slow%0d_stall_c%0d", s, c), stallM, (c < 3));
        tick();
        if (c < 3) chk($sformatf("slow%0d_bubble_c%0d", s, c), {RegWriteW, MemtoRegW}, 0);
      end
      chk($sformatf("slow%0d_rd", s), ReadDataW, s ? 32'hFFFFFF80 : 32'h00000080);
      chk($sformatf("slow%0d_ctl", s), {RegWriteW, MemtoRegW}, 2'b11);
    end

    // ---------------- sw with no ack: timeout
    set_op(0, 1, 0, 0, 2'b10, 32'h400, 32'hCAFEF00D, 5'd0, 0);
    bus.mem_ack = 1'b0;
    sc = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      #4;
      if (stallM) begin sc++; tick(); end
      else done = 1;
    end
    chk("to_ended", done, 1);
    chk("to_stall_cycles", sc, TIMEOUT);
    chk("to_req_last", bus.mem_req, 1);
    tick();
    chk("to_buserr", exc_buserrW, 1);
    chk("to_rw", RegWriteW, 0);
    set_op(1, 0, 1, 0, 2'b10, 32'h100, 32'h0, 5'd4, 0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BADF00D;
    #4;
    chk("to_idle_stall", stallM, 0);
    tick();
    chk("to_buserr_clear", exc_buserrW, 0);
    chk("to_after_rd", ReadDataW, 32'h0BADF00D);

    // ---------------- reset asserted while in WAIT
    bus.mem_ack = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_req", bus.mem_req, 0);
    chk("rstw_stall", stallM, 0);
    chk("rstw_w", {RegWriteW, MemtoRegW, syscallW, exc_misalignW, exc_buserrW}, 0);
    chk("rstw_wdata", {ReadDataW, ALUOutW}, 0);
    tick();
    rst_n = 1'b1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
    #4;
    chk("rstw_lw_req", bus.mem_req, 1);
    chk("rstw_lw_stall", stallM, 0);
    tick();
    chk("rstw_lw_rd", ReadDataW, 32'hDEADBEEF);
    chk("rstw_lw_ctl", {RegWriteW, MemtoRegW}, 2'b11);

    // ---------------- randomized ops against the reference model
    for (int k = 0; k < 200; k++) begin
      logic mtr, mw, rw, sgn, sys, memop, mis, issue, berr;
      logic [1:0] sz;
      logic [31:0] tmp, addr, wd, rd;
      logic [4:0] wreg;
      int unsigned off, lat, nstall, r, kind;
      kind = $urandom_range(0, 3);
      mtr = (kind == 1) || (kind == 3);
      mw  = (kind == 2) || (kind == 3);
      rw  = 1'($urandom_range(0, 1));
      sgn = 1'($urandom_range(0, 1));
      sys = ($urandom_range(0, 7) == 0);
      sz  = 2'($urandom_range(0, 3));
      off = $urandom_range(0, 3);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) off = off & 2;
        else if (sz >= 2'd2) off = 0;
      end
      tmp = $urandom();
      addr = (tmp & 32'hFFFFFFFC) | off;
      wd = $urandom(); rd = $urandom(); wreg = 5'($urandom());
      r = $urandom_range(0, 19);
      if (r < 13) lat = r % 4;
      else if (r < 15) lat = TIMEOUT;
      else if (r < 17) lat = TIMEOUT - 1;
      else lat = TIMEOUT + 1;

      memop = mtr || mw;
      mis = memop && ((sz == 2'd1 && off[0]) || (sz >= 2'd2 && off != 0));
      issue = memop && !mis;
      nstall = !issue ? 0 : (lat <= TIMEOUT ? lat : TIMEOUT);
      berr = issue && (lat > TIMEOUT);

      set_op(mtr, mw, rw, sgn, sz, addr, wd, wreg, sys);
      for (int unsigned c = 0; c <= nstall; c++) begin
        bus.mem_ack = issue ? (c == lat) : 1'($urandom_range(0, 1));
        bus.mem_rdata = (issue && c == lat) ? rd : $urandom();
        #4;
        chk($sformatf("rnd%0d_req", k), bus.mem_req, issue);
        chk($sformatf("rnd%0d_stall", k), stallM, (c < nstall));
        if (issue) begin
          chk($sformatf("rnd%0d_addr", k), bus.mem_addr, addr & 32'hFFFFFFFC);
          chk($sformatf("rnd%0d_be", k), bus.mem_be, m_be(sz, off));
          chk($sformatf("rnd%0d_we", k), bus.mem_we, mw);
          if (mw) chk($sformatf("rnd%0d_wdata", k), bus.mem_wdata, m_wdata(wd, sz));
        end
        tick();
        if (c < nstall)
          chk($sformatf("rnd%0d_bubble", k),
              {RegWriteW, MemtoRegW, syscallW, exc_misalignW, exc_buserrW}, 0);
      end
      chk($sformatf("rnd%0d_rw", k), RegWriteW, rw && !mis && !berr);
      chk($sformatf("rnd%0d_exc", k), {exc_misalignW, exc_buserrW}, {mis, berr});
      chk($sformatf("rnd%0d_sys", k), syscallW, sys);
      chk($sformatf("rnd%0d_alu", k), ALUOutW, addr);
      chk($sformatf("rnd%0d_wreg", k), WriteRegW, wreg);
      if (!berr) chk($sformatf("rnd%0d_mtr", k), MemtoRegW, mtr && !mis);
      if (issue && !berr && mtr && !mw)
        chk($sformatf("rnd%0d_rd", k), ReadDataW, m_load(rd, sz, sgn, off));
    end

    nop();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_stage_hs.md
# mem_stage_hs

Parametrised successor to the single-cycle memory stage of the 5-stage MIPS pipeline. It sits between the EX/MEM register and writeback and talks to an external data memory over a req/ack handshake with variable latency. It supports byte, halfword and word accesses with sign or zero extension, detects misalignment and memory timeout, and raises a stall to the hazard unit while an access is outstanding. It owns the MEM/WB pipeline register; all W-side outputs are registered.

## Interface
- ADDR_W, 32: address width.
- REG_W, 5: register-index width.
- TIMEOUT, 16: maximum cycles in WAIT before a bus error. Must be ≥ 2. Counter width is clog2(TIMEOUT+1).
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- RegWriteM, MemToRegM, MemWriteM, syscallM  in  1 each  control from EX/MEM.
- SizeM  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved, treated as word.
- SignedM  in  1  sign-extend loads when 1.
- ALUOutM  in  ADDR_W  effective address or ALU result.
- WriteDataM  in  32  store data, right-aligned.
- WriteRegM  in  REG_W  destination register.
- mem_req  out  1  access request.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  word address: ALUOutM with bits [1:0] forced to 0.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  access complete; qualifies mem_rdata.
- mem_rdata  in  32  read word.
- stallM  out  1  hold F/D/E/M stages.
- WriteRegM_hazard  out  REG_W  equals WriteRegM, combinational, for forwarding.
- RegWriteW, MemtoRegW, syscallW  out  1 each  registered.
- ReadDataW, ALUOutW  out  32 / ADDR_W  registered.
- WriteRegW  out  REG_W  registered.
- exc_misalignW, exc_buserrW  out  1 each  registered one-cycle exception flags.

## Operation
- A memory op exists when MemToRegM or MemWriteM is 1. If both are 1, the access is a write.
- Misalignment:
  - half with addr[0]=1;
  - word with addr[1:0]≠0.
  - A misaligned op issues no request. It completes immediately with exc_misalignW=1, and RegWriteW=0, MemtoRegW=0.
- Byte enables:
  - byte: 1<<addr[1:0];
  - half: 0011 or 1100 by addr[1];
  - word: 1111.
- mem_wdata:
  - byte: WriteDataM[7:0] replicated ×4;
  - half: WriteDataM[15:0] replicated ×2;
  - word: unchanged.
- Loads select the addressed lane and extend to 32 bits. The extension is sign or zero per SignedM. Word loads ignore SignedM.
- FSM states: IDLE, WAIT.
  - IDLE:
    - mem_req = aligned memory op.
    - If mem_ack is 1 in the same cycle, the op completes and the FSM stays in IDLE.
    - Otherwise the FSM goes to WAIT with cnt=1.
  - WAIT:
    - mem_req=1. mem_we, mem_addr, mem_be and mem_wdata are driven from the held M inputs.
    - If mem_ack=1, the op completes and the FSM goes to IDLE.
    - Else if cnt=TIMEOUT, the op completes with exc_buserrW=1 and RegWriteW=0, and the FSM goes to IDLE.
    - Else cnt increments.
    - If mem_ack and the timeout fall in the same cycle, the ack wins.
- stallM = mem_req & ~mem_ack & ~timeout_this_cycle. Upstream holds all M inputs stable while stallM=1.
- Non-memory ops complete in the cycle they arrive. They never assert mem_req.
- syscallM passes to syscallW with the instruction. It is never stalled independently.

## Timing
- Reset, asynchronous:
  - state=IDLE, cnt=0;
  - all W outputs 0, including exc flags.
  - mem_req and stallM are combinational. They go to 0 during reset.
- The MEM/WB register updates every cycle.
  - On a completing cycle it captures the instruction's results.
  - On a stalled cycle it loads a bubble: RegWriteW=0, MemtoRegW=0, syscallW=0, exc flags 0. The data fields hold their values.
- Latency:
  - zero-wait ack: result visible at W one cycle after the M cycle.
  - N-cycle ack: stallM is high for N cycles, and W is valid on the cycle after the ack.
- Back-to-back memory ops: a new request may be issued in the cycle after an ack. There are no dead cycles.
- If rst_n asserts mid-WAIT, the request is dropped immediately. The memory side must tolerate an abandoned request.
- mem_ack while mem_req=0 is ignored.

## Test plan
- lw at 0x100, ack in the same cycle, mem_rdata=0xDEADBEEF -> no stall; next cycle ReadDataW=0xDEADBEEF, MemtoRegW=1, RegWriteW=1.
- lb SignedM=1 at 0x103, rdata=0x80FFFFFF, ack after 3 cycles -> stallM high for 3 cycles; W shows bubbles, then ReadDataW=0xFFFFFF80. The same access as lbu gives 0x00000080.
- sh at 0x202, data 0x1234ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1; RegWriteW=0.
- lw at 0x101 -> mem_req stays 0, no stall; next cycle exc_misalignW=1, RegWriteW=0.
- sw with mem_ack never asserted, TIMEOUT=16 -> stallM high for exactly 16 cycles; exc_buserrW=1 on the following cycle; the FSM returns to IDLE.
- rst_n low during WAIT, then released -> mem_req=0 and stallM=0 at once; all W outputs 0; the next lw behaves as in the first scenario.
